// File: rtl/start_pkg.sv
// Shared constants and types for the start screen pixel fetch path.
// Holds the image/screen geometry, the ROM shape, the FSM states and the ROM contents.
package start_pkg;

  localparam int IMG_W      = 320;
  localparam int IMG_H      = 240;
  localparam int SCR_W      = 640;
  localparam int SCR_H      = 480;
  localparam int ROM_ADDR_W = 17;
  localparam int ROM_DEPTH  = 76800;

  typedef enum logic {
    WIPE,
    SHOW
  } state_e;

  // Contents of the start image ROM: a 16-colour ramp (addr mod 16).
  // Reads past the last entry return index 0.
  function automatic logic [3:0] rom_word(input logic [ROM_ADDR_W-1:0] a);
    logic [3:0] w;
    w = '0;
    if (a < ROM_ADDR_W'(ROM_DEPTH))
      w = a[3:0];
    return w;
  endfunction

endpackage

// File: rtl/start_rom.sv
// 76800 x 4 start image ROM, synchronous read with one cycle of latency.
// Ports: clk_i clock, addr_i read address, data_o palette index of addr_i one cycle later.
module start_rom
  import start_pkg::*;
(
  input  logic                  clk_i,
  input  logic [ROM_ADDR_W-1:0] addr_i,
  output logic [3:0]            data_o
);

  always_ff @(posedge clk_i) begin
    data_o <= rom_word(addr_i);
  end

endmodule

// File: rtl/start_index_gen.sv
// Start screen pixel fetch: DrawX/DrawY -> ROM address -> palette index, two-cycle pipeline.
// Ports: vga_clk, Reset (async high), DrawX, DrawY, blank in; index, blank_out, wipe_done out.
module start_index_gen
  import start_pkg::*;
#(
  parameter int unsigned WIPE_STEP   = 8,
  parameter int unsigned BLINK_X0    = 224,
  parameter int unsigned BLINK_X1    = 415,
  parameter int unsigned BLINK_Y0    = 352,
  parameter int unsigned BLINK_Y1    = 383,
  parameter int unsigned BLINK_SHIFT = 5,
  parameter logic [3:0]  BG_INDEX    = 4'h0
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       blank,
  output logic [3:0] index,
  output logic       blank_out,
  output logic       wipe_done
);

  state_e     state_q;
  logic [9:0] wipe_line_q;
  logic [5:0] frame_cnt_q;
  logic       wipe_done_q;

  logic       hide_q,  hide_d;
  logic       blank1_q;
  logic [3:0] index_q, index_d;
  logic       blank2_q;

  logic                  tick;
  logic                  in_range;
  logic                  in_blink;
  logic [ROM_ADDR_W-1:0] addr_d;
  logic [3:0]            rom_q;
  logic [10:0]           wipe_sum;
  logic [9:0]            wipe_next;

  assign tick = (DrawX == 10'(SCR_W - 1)) &&
                (DrawY == 10'(SCR_H - 1));

  assign in_range = (DrawX < 10'(SCR_W)) &&
                    (DrawY < 10'(SCR_H));

  assign in_blink = (DrawX >= 10'(BLINK_X0)) &&
                    (DrawX <= 10'(BLINK_X1)) &&
                    (DrawY >= 10'(BLINK_Y0)) &&
                    (DrawY <= 10'(BLINK_Y1));

  // y*320 + x as (y<<8)+(y<<6)+x; forced to 0 offscreen so
  // the ROM never sees an address past its last entry.
  always_comb begin
    addr_d = '0;
    if (in_range)
      addr_d = (ROM_ADDR_W'(DrawY[9:1]) << 8) +
               (ROM_ADDR_W'(DrawY[9:1]) << 6) +
                ROM_ADDR_W'(DrawX[9:1]);
  end

  always_comb begin
    hide_d = !in_range || !blank;
    if (state_q == WIPE && DrawY >= wipe_line_q)
      hide_d = 1'b1;
    if (state_q == SHOW && frame_cnt_q[BLINK_SHIFT] && in_blink)
      hide_d = 1'b1;
  end

  // Saturate so a large step can never wrap back on screen.
  assign wipe_sum  = {1'b0, wipe_line_q} + 11'(WIPE_STEP);
  assign wipe_next = wipe_sum[10] ? 10'h3FF : wipe_sum[9:0];

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= WIPE;
      wipe_line_q <= '0;
      frame_cnt_q <= '0;
      wipe_done_q <= 1'b0;
    end else if (tick) begin
      case (state_q)
        WIPE: begin
          wipe_line_q <= wipe_next;
          if (wipe_next >= 10'(SCR_H)) begin
            state_q     <= SHOW;
            wipe_done_q <= 1'b1;
          end
        end
        SHOW: frame_cnt_q <= frame_cnt_q + 6'd1;
        default: state_q <= WIPE;
      endcase
    end
  end

  // Stage 1: the ROM's own address register plus hide/blank.
  start_rom u_rom (
    .clk_i  (vga_clk),
    .addr_i (addr_d),
    .data_o (rom_q)
  );

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      hide_q   <= 1'b0;
      blank1_q <= 1'b0;
    end else begin
      hide_q   <= hide_d;
      blank1_q <= blank;
    end
  end

  // rom_q has no reset, so a cleared blank1_q also masks it.
  assign index_d = (hide_q || !blank1_q) ? BG_INDEX : rom_q;

  // Stage 2
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      index_q  <= BG_INDEX;
      blank2_q <= 1'b0;
    end else begin
      index_q  <= index_d;
      blank2_q <= blank1_q;
    end
  end

  assign index     = index_q;
  assign blank_out = blank2_q;
  assign wipe_done = wipe_done_q;

endmodule

// File: tb/tb_start_index_gen.sv
// Directed bench for start_index_gen: table-driven pixels plus wipe, blink and reset sequences.
// Ticks are forced by presenting (639,479) for one cycle rather than scanning whole frames.
module tb_start_index_gen;

  logic       vga_clk = 1'b0;
  logic       Reset;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic [3:0] index;
  logic       blank_out;
  logic       wipe_done;

  int checks = 0;
  int errors = 0;

  always #5 vga_clk = ~vga_clk;

  start_index_gen dut (
    .vga_clk   (vga_clk),
    .Reset     (Reset),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .blank     (blank),
    .index     (index),
    .blank_out (blank_out),
    .wipe_done (wipe_done)
  );

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       b;
    logic [3:0] idx;
    logic       bo;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Present a pixel and wait out the two-cycle pipeline.
  task automatic px(input logic [9:0] x, input logic [9:0] y,
                    input logic b);
    DrawX = x;
    DrawY = y;
    blank = b;
    repeat (2) @(posedge vga_clk);
    #1;
  endtask

  task automatic pxchk(input string name, input logic [9:0] x,
                       input logic [9:0] y, input logic [3:0] exp);
    px(x, y, 1'b1);
    chk(name, index, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      DrawX = 10'd639;
      DrawY = 10'd479;
      blank = 1'b1;
      @(posedge vga_clk);
      #1;
      DrawX = 10'd640;
      blank = 1'b0;
    end
  endtask

  logic [7:0] bpat;
  logic       bprev;

  initial begin
    tbl[0] = '{10'd5,   10'd3,   1'b1, 4'h2, 1'b1};
    tbl[1] = '{10'd700, 10'd3,   1'b1, 4'h0, 1'b1};
    tbl[2] = '{10'd100, 10'd3,   1'b0, 4'h0, 1'b0};
    tbl[3] = '{10'd638, 10'd479, 1'b1, 4'hF, 1'b1};
    tbl[4] = '{10'd0,   10'd480, 1'b1, 4'h0, 1'b1};
    tbl[5] = '{10'd300, 10'd360, 1'b1, 4'h6, 1'b1};
    tbl[6] = '{10'd226, 10'd353, 1'b1, 4'h1, 1'b1};
    tbl[7] = '{10'd31,  10'd17,  1'b1, 4'hF, 1'b1};
    tbl[8] = '{10'd639, 10'd0,   1'b1, 4'hF, 1'b1};
    tbl[9] = '{10'd5,   10'd524, 1'b1, 4'h0, 1'b1};

    Reset = 1'b1;
    DrawX = 10'd0;
    DrawY = 10'd0;
    blank = 1'b0;
    repeat (3) @(posedge vga_clk);
    #1;
    chk("rst_index", index, 4'h0);
    chk("rst_blank_out", {3'b0, blank_out}, 4'h0);
    chk("rst_wipe_done", {3'b0, wipe_done}, 4'h0);
    Reset = 1'b0;

    // Wipe: nothing visible before the first tick.
    pxchk("wipe0_row0", 10'd10, 10'd0, 4'h0);
    tick(1);
    pxchk("wipe8_row7", 10'd5, 10'd7, 4'h2);
    pxchk("wipe8_row8", 10'd5, 10'd8, 4'h0);
    tick(58);
    chk("wipe59_done", {3'b0, wipe_done}, 4'h0);
    pxchk("wipe472_row471", 10'd5, 10'd471, 4'h2);
    pxchk("wipe472_row472", 10'd5, 10'd472, 4'h0);
    tick(1);
    chk("wipe60_done", {3'b0, wipe_done}, 4'h1);
    pxchk("show_blink_off", 10'd300, 10'd360, 4'h6);

    for (int i = 0; i < 10; i++) begin
      px(tbl[i].x, tbl[i].y, tbl[i].b);
      chk($sformatf("tbl%0d_index", i), index, tbl[i].idx);
      chk($sformatf("tbl%0d_blank", i), {3'b0, blank_out},
          {3'b0, tbl[i].bo});
    end

    // Blink: frame_cnt stayed 0 on the crossing tick, so 31
    // more ticks keep bit 5 low and the 32nd sets it.
    tick(31);
    pxchk("blink31_in", 10'd300, 10'd360, 4'h6);
    tick(1);
    pxchk("blink32_in", 10'd300, 10'd360, 4'h0);
    pxchk("blink32_above", 10'd300, 10'd351, 4'h6);
    pxchk("blink32_below", 10'd300, 10'd384, 4'h6);
    pxchk("blink32_row383", 10'd300, 10'd383, 4'h0);
    pxchk("blink32_left", 10'd223, 10'd352, 4'hF);
    pxchk("blink32_x0", 10'd226, 10'd352, 4'h0);
    pxchk("blink32_right", 10'd418, 10'd383, 4'h1);
    tick(31);
    pxchk("blink63_in", 10'd300, 10'd360, 4'h0);
    tick(1);
    pxchk("blink64_in", 10'd300, 10'd360, 4'h6);

    // blank_out is blank delayed two cycles.
    bpat  = 8'b0011_0101;
    bprev = blank;
    DrawX = 10'd100;
    DrawY = 10'd100;
    for (int k = 0; k < 8; k++) begin
      blank = bpat[k];
      @(posedge vga_clk);
      #1;
      if (k > 0)
        chk($sformatf("bdelay%0d", k), {3'b0, blank_out},
            {3'b0, bprev});
      bprev = bpat[k];
    end

    // Asynchronous reset mid-frame.
    pxchk("pre_reset", 10'd300, 10'd200, 4'h6);
    @(posedge vga_clk);
    #3 Reset = 1'b1;
    #1;
    chk("midrst_index", index, 4'h0);
    chk("midrst_done", {3'b0, wipe_done}, 4'h0);
    @(posedge vga_clk);
    #1 Reset = 1'b0;
    pxchk("rewipe_row7", 10'd5, 10'd7, 4'h0);
    tick(1);
    pxchk("rewipe8_row7", 10'd5, 10'd7, 4'h2);
    pxchk("rewipe8_row8", 10'd5, 10'd8, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
